// File: rtl/ec_ctrl_param.sv
// ec_ctrl_param: raster-scan controller for a padded conv + pool layer.
// It sequences pixel fetch, per-position PE compute and the index SRAM writes.
module ec_ctrl_param #(
  parameter int H      = 8,
  parameter int W      = 32,
  parameter int FH     = 3,
  parameter int FW     = 3,
  parameter int PAD    = 1,
  parameter int POOL_H = 2,
  parameter int POOL_W = 2,
  parameter int D_OUT  = 512,
  parameter int N_PE   = 2,
  parameter int M      = 1,
  localparam int HP    = H + 2 * PAD,
  localparam int WP    = W + 2 * PAD,
  localparam int HC    = HP - FH + 1,
  localparam int WC    = WP - FW + 1,
  localparam int K     = M * D_OUT / N_PE,
  localparam int NIDX  = (HC / POOL_H) * (WC / POOL_W) * K,
  localparam int KW    = K > 1 ? $clog2(K) : 1,
  localparam int AW    = NIDX > 1 ? $clog2(NIDX) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          data_in_en,
  output logic          in_ready,
  output logic          fmap_in_shiftreg_en,
  output logic          pad_mux_sel,
  output logic          pe_en,
  output logic          w_rom_en,
  output logic [KW-1:0] w_rom_addr,
  output logic          fmap_out_shiftreg_en,
  output logic          index_sram_en,
  output logic          index_sram_wr,
  output logic [AW-1:0] index_sram_addr,
  output logic          last_row_sel,
  output logic          busy,
  output logic          data_out_en,
  output logic          tg_next
);
  localparam int RW = $clog2(HP + 1);
  localparam int CW = $clog2(WP + 1);
  localparam logic [RW-1:0] R_LO  = RW'(PAD);
  localparam logic [RW-1:0] R_HI  = RW'(H + PAD);
  localparam logic [RW-1:0] R_WIN = RW'(FH - 1);
  localparam logic [RW-1:0] R_END = RW'(HP - 1);
  localparam logic [RW-1:0] R_PH  = RW'(POOL_H);
  localparam logic [CW-1:0] C_LO  = CW'(PAD);
  localparam logic [CW-1:0] C_HI  = CW'(W + PAD);
  localparam logic [CW-1:0] C_WIN = CW'(FW - 1);
  localparam logic [CW-1:0] C_END = CW'(WP - 1);
  localparam logic [CW-1:0] C_PW  = CW'(POOL_W);
  localparam logic [KW-1:0] K_END = KW'(K - 1);
  localparam logic [AW-1:0] ADDR_NIDX = AW'(NIDX - 1);

  typedef enum logic [1:0] {IDLE, FETCH, COMPUTE, DONE} state_t;

  state_t        r_state, w_next;
  logic [RW-1:0] r_r, w_orow;
  logic [CW-1:0] r_c, w_ocol;
  logic [KW-1:0] r_k;
  logic [AW-1:0] r_addr;
  logic          w_fetch, w_comp, w_pad, w_pool, w_win, w_klast, w_end, w_fetch_done, w_adv;

  assign w_fetch      = r_state == FETCH;
  assign w_comp       = r_state == COMPUTE;
  assign w_pad        = r_r < R_LO || r_r >= R_HI || r_c < C_LO || r_c >= C_HI;
  assign w_orow       = r_r - R_WIN;
  assign w_ocol       = r_c - C_WIN;
  assign w_pool       = (w_orow % R_PH == R_PH - RW'(1)) && (w_ocol % C_PW == C_PW - CW'(1));
  assign w_win        = r_r >= R_WIN && r_c >= C_WIN;
  assign w_klast      = r_k == K_END;
  assign w_end        = r_r == R_END && r_c == C_END;
  assign w_fetch_done = w_fetch && (w_pad || data_in_en);
  assign w_adv        = (w_fetch_done && !w_win) || (w_comp && w_klast && !w_end);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start ? FETCH : IDLE;
      FETCH:   w_next = (w_fetch_done && w_win) ? COMPUTE : FETCH;
      COMPUTE: w_next = !w_klast ? COMPUTE : (w_end ? DONE : FETCH);
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign in_ready             = w_fetch && !w_pad;
  assign pad_mux_sel          = w_fetch && w_pad;
  assign fmap_in_shiftreg_en  = w_fetch && (w_pad || data_in_en);
  assign pe_en                = w_comp;
  assign w_rom_en             = w_comp;
  assign w_rom_addr           = r_k;
  assign fmap_out_shiftreg_en = w_comp && w_pool;
  assign index_sram_en        = w_comp && w_pool;
  assign index_sram_wr        = w_comp && w_pool;
  assign index_sram_addr      = r_addr;
  assign last_row_sel         = w_comp && r_r == R_END;
  assign busy                 = r_state != IDLE;
  assign data_out_en          = r_state == DONE;
  assign tg_next              = r_state == DONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_r     <= '0;
      r_c     <= '0;
      r_k     <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_r    <= '0;
        r_c    <= '0;
        r_k    <= '0;
        r_addr <= '0;
      end else begin
        if (w_adv) begin
          r_c <= r_c == C_END ? '0 : r_c + CW'(1);
          if (r_c == C_END) r_r <= r_r + RW'(1);
        end
        if (w_comp) r_k <= w_klast ? '0 : r_k + KW'(1);
        if (index_sram_wr) r_addr <= r_addr == ADDR_NIDX ? '0 : r_addr + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ec_ctrl_param.sv
// tb_ec_ctrl_param: scoreboard bench for ec_ctrl_param with a 4x4 frame, K=2, NIDX=8.
module tb_ec_ctrl_param;
  logic       clk = 0, rst = 0, start = 0, data_in_en = 1;
  logic       in_ready, fmap_in_shiftreg_en, pad_mux_sel, pe_en, w_rom_en;
  logic [0:0] w_rom_addr;
  logic       fmap_out_shiftreg_en, index_sram_en, index_sram_wr;
  logic [2:0] index_sram_addr;
  logic       last_row_sel, busy, data_out_en, tg_next;

  typedef struct {int acc; int pe; int lrs; int pad; int cyc;} frame_t;

  int     checks = 0, errors = 0;
  int     q_addr[$];
  frame_t q_frame[$];
  int     n_acc, n_pe, n_lrs, n_pad, n_cyc;

  ec_ctrl_param #(.H(4), .W(4), .D_OUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in_en(data_in_en),
    .in_ready(in_ready), .fmap_in_shiftreg_en(fmap_in_shiftreg_en),
    .pad_mux_sel(pad_mux_sel), .pe_en(pe_en), .w_rom_en(w_rom_en),
    .w_rom_addr(w_rom_addr), .fmap_out_shiftreg_en(fmap_out_shiftreg_en),
    .index_sram_en(index_sram_en), .index_sram_wr(index_sram_wr),
    .index_sram_addr(index_sram_addr), .last_row_sel(last_row_sel),
    .busy(busy), .data_out_en(data_out_en), .tg_next(tg_next)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({in_ready, fmap_in_shiftreg_en, pad_mux_sel, pe_en, w_rom_en, w_rom_addr,
                 fmap_out_shiftreg_en, index_sram_en, index_sram_wr, index_sram_addr,
                 last_row_sel, busy, data_out_en, tg_next});
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      n_acc = 0; n_pe = 0; n_lrs = 0; n_pad = 0; n_cyc = 0;
    end else begin
      if (busy) n_cyc++;
      if (in_ready && data_in_en) n_acc++;
      if (pe_en) n_pe++;
      if (last_row_sel) begin
        n_lrs++;
        chk("lrs_in_compute", int'(pe_en), 1);
      end
      if (pad_mux_sel) begin
        n_pad++;
        chk("pad_in_ready", int'(in_ready), 0);
        chk("pad_shift", int'(fmap_in_shiftreg_en), 1);
      end
      if (index_sram_wr) begin
        if (q_addr.size() == 0) chk("unexpected_write", int'(index_sram_addr), -1);
        else chk("index_addr", int'(index_sram_addr), q_addr.pop_front());
        chk("wr_side_enables", int'({fmap_out_shiftreg_en, index_sram_en}), 3);
      end
      if (data_out_en) begin
        chk("tg_next", int'(tg_next), 1);
        if (q_frame.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          frame_t e;
          e = q_frame.pop_front();
          chk("accepts", n_acc, e.acc);
          chk("pe_cycles", n_pe, e.pe);
          chk("last_row_cycles", n_lrs, e.lrs);
          chk("pad_positions", n_pad, e.pad);
          chk("frame_cycles", n_cyc, e.cyc);
        end
        n_acc = 0; n_pe = 0; n_lrs = 0; n_pad = 0; n_cyc = 0;
      end
    end
  end

  task automatic wait_for(input string name, input int sel);
    int n = 0;
    while (!(sel == 0 ? data_out_en : sel == 1 ? in_ready : pe_en) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_frame(input int stall, input bit poke);
    frame_t e;
    for (int i = 0; i < 8; i++) q_addr.push_back(i);
    e = '{acc: 16, pe: 32, lrs: 8, pad: 20, cyc: 69 + stall};
    q_frame.push_back(e);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    if (stall > 0) begin
      data_in_en = 0;
      wait_for("first_real", 1);
      for (int i = 0; i < stall; i++) begin
        chk("stall_ready", int'(in_ready), 1);
        chk("stall_pe", int'(pe_en), 0);
        chk("stall_shift", int'(fmap_in_shiftreg_en), 0);
        @(negedge clk);
      end
      data_in_en = 1;
    end
    if (poke) begin
      repeat (10) @(negedge clk);
      start = 1;
      repeat (3) @(negedge clk);
      start = 0;
      wait_for("poke_pe", 2);
      start = 1;
      @(negedge clk) start = 0;
    end
    wait_for("done", 0);
    @(negedge clk);
    chk("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    rst = 1;
    @(negedge clk);
    chk("idle_no_start", all_outs(), 0);
    run_frame(0, 0);
    run_frame(5, 0);
    run_frame(0, 1);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    wait_for("abort_pe", 2);
    chk("abort_in_compute", int'(pe_en), 1);
    rst = 0;
    @(negedge clk);
    chk("abort_outs", all_outs(), 0);
    @(negedge clk) rst = 1;
    @(negedge clk);
    chk("abort_wait_start", int'(busy), 0);
    run_frame(0, 0);
    chk("addr_queue_empty", q_addr.size(), 0);
    chk("frame_queue_empty", q_frame.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ec_ctrl_param.md
EC_CTRL_PARAM -- requirements
Module: ec_ctrl_param

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H, 8, unpadded input rows
- W, 32, unpadded input columns
- FH, 3, filter height
- FW, 3, filter width
- PAD, 1, zero-pad border width
- POOL_H, 2, pool window height
- POOL_W, 2, pool window width
- D_OUT, 512, output channels
- N_PE, 2, PE lanes
- M, 1, passes per position
REQ-002 Derived values:
- HP=H+2*PAD, WP=W+2*PAD.
- HC=HP-FH+1, WC=WP-FW+1.
- K=M*D_OUT/N_PE.
- NIDX=(HC/POOL_H)*(WC/POOL_W)*K.
- Legal only if HC%POOL_H==0, WC%POOL_W==0, D_OUT%N_PE==0.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- rst, in, 1, synchronous active-low reset
- start, in, 1, begin frame
- data_in_en, in, 1, input pixel valid
- in_ready, out, 1, pixel accepted this cycle when data_in_en=1
- fmap_in_shiftreg_en, out, 1, shift input window
- pad_mux_sel, out, 1, select zero pad
- pe_en, out, 1, PE compute enable
- w_rom_en, out, 1, weight ROM enable
- w_rom_addr, out, clog2(K), weight ROM address
- fmap_out_shiftreg_en, out, 1, shift pooled output
- index_sram_en, out, 1, index SRAM enable
- index_sram_wr, out, 1, index SRAM write
- index_sram_addr, out, clog2(NIDX), index SRAM address
- last_row_sel, out, 1, last conv row mux select
- busy, out, 1, frame in progress
- data_out_en, out, 1, frame complete pulse
- tg_next, out, 1, trigger next layer
REQ-004 The single clock is clk; reset rst is synchronous and active-low.

Function
REQ-005 The FSM has states IDLE, FETCH, COMPUTE, DONE and scans the padded frame raster-order with counters r (0..HP-1) and c (0..WP-1).
REQ-006 In IDLE, start=1 moves to FETCH and clears r, c, k and index_sram_addr; start in any other state is ignored.
REQ-007 A position is a pad position when r<PAD, r>=H+PAD, c<PAD or c>=W+PAD.
REQ-008 FETCH at a pad position:
- pad_mux_sel=1, fmap_in_shiftreg_en=1, in_ready=0.
- The position completes in one cycle regardless of data_in_en.
REQ-009 FETCH at a real position:
- in_ready=1, fmap_in_shiftreg_en=data_in_en.
- The block holds r, c and state while data_in_en=0 (stall).
REQ-010 When a FETCH position completes:
- If r>=FH-1 and c>=FW-1, the next state is COMPUTE.
- Otherwise the position advances and the state stays FETCH.
REQ-011 COMPUTE lasts exactly K cycles with k=0..K-1, pe_en=1, w_rom_en=1, w_rom_addr=k.
REQ-012 Pool flag: let orow=r-FH+1 and ocol=c-FW+1; pool_last=(orow%POOL_H==POOL_H-1)&&(ocol%POOL_W==POOL_W-1).
REQ-013 During COMPUTE with pool_last=1:
- fmap_out_shiftreg_en=index_sram_en=index_sram_wr=1 every cycle.
- index_sram_addr increments by 1 after each write.
REQ-014 During COMPUTE with pool_last=0, no index SRAM or output shift activity occurs.
REQ-015 last_row_sel=1 during COMPUTE when orow==HC-1, and is 0 otherwise.
REQ-016 Position advance: c increments; at c==WP-1, c wraps to 0 and r increments.
REQ-017 After the last COMPUTE cycle:
- If r==HP-1 and c==WP-1, the next state is DONE.
- Otherwise the position advances and the next state is FETCH.
REQ-018 DONE lasts one cycle with data_out_en=1 and tg_next=1, then returns to IDLE.
REQ-019 busy=1 in FETCH, COMPUTE and DONE.
REQ-020 data_in_en has no effect outside real-position FETCH.
REQ-021 All outputs are combinational from state and counters; every enable not named for a state is 0.

Reset
REQ-022 rst=0 at a clock edge forces IDLE and clears r, c, k and index_sram_addr, including mid-frame.
REQ-023 Reset values: all outputs 0; w_rom_addr=0; index_sram_addr=0.
REQ-024 After rst returns to 1, the block waits for start.

Verification
REQ-025 The bench covers the following scenarios with H=W=4, FH=FW=3, PAD=1, POOL=2, D_OUT=4, N_PE=2, M=1 (K=2, NIDX=8):
- Continuous valid -> 36 positions, 16 in_ready accepts, 32 pe_en cycles, 8 index writes at addr 0..7, one data_out_en/tg_next pulse.
- data_in_en low 5 cycles at the first real pixel -> r and c held, no pe_en; totals unchanged; frame longer by 5 cycles.
- Pad rows r=0 and r=5 -> pad_mux_sel=1, in_ready=0, no data consumed.
- last_row_sel -> high only in COMPUTE for r=5, c=2..5 (8 cycles).
- rst=0 mid-COMPUTE -> next cycle IDLE, all outputs 0; new start reruns frame with index addr from 0.
- start asserted while busy -> no effect on counters or sequence.
